shift_arbiter: RTL and testbench

Sequencer and two-port arbiter for the shared 16-bit barrel shifter.
- The shifter's stages sample `shamt`/`dir` every cycle. Its result is therefore only correct if operands stay stable for its full depth.
- This block accepts shift requests from two requesters, grants one at a time round-robin, and holds the granted operands on the shifter until the result and zero flag settle.
- It returns the result with the requester ID.
- It sits between the execute-stage requesters and the shifter instance in the datapath.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_arbiter_rr_arb2.sv | 20 ++
 rtl/shift_arbiter.sv | 130 +++++++++++++
 tb/tb_shift_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the barrel shifter and its arbiter. These are the shift-direction
// codes, the sequencer state encoding and the shifter's operand-to-zero-flag latency.
package shift_pkg;

    localparam int SH_LAT = 5;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_SLL  = 2'b01;
    localparam logic [1:0] SH_SRL  = 2'b10;
    localparam logic [1:0] SH_SRA  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin grant. When both requesters are pending, the one not served last wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = last ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Sequencer and two-port arbiter for the shared barrel shifter. It grants one request at a time
// and keeps the operands stable until the shifter's result and zero flag have settled.
module shift_arbiter #(
    parameter int WIDTH  = 16,
    parameter int SH_LAT = shift_pkg::SH_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_src,
    input  logic [WIDTH-1:0] req1_src,
    input  logic [3:0]       req0_shamt,
    input  logic [3:0]       req1_shamt,
    input  logic [1:0]       req0_dir,
    input  logic [1:0]       req1_dir,
    output logic [WIDTH-1:0] sh_src,
    output logic [3:0]       sh_shamt,
    output logic [1:0]       sh_dir,
    input  logic [WIDTH-1:0] sh_out,
    input  logic             sh_zr,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zr,
    output logic             busy
);
    import shift_pkg::*;

    localparam int CNT_W = $clog2(SH_LAT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   hold_src_q, hold_src_d;
    logic [3:0]         hold_shamt_q, hold_shamt_d;
    logic [1:0]         hold_dir_q, hold_dir_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_zr_q, rsp_zr_d;

    logic               idle;
    logic [1:0]         grant;

    assign idle = (state_q == IDLE);

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .last  (last_q),
        .en    (idle),
        .grant (grant)
    );

    // A non-zero grant only appears while idle and with its valid high, so it marks the handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        hold_src_d   = hold_src_q;
        hold_shamt_d = hold_shamt_q;
        hold_dir_d   = hold_dir_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zr_d     = rsp_zr_q;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    hold_src_d   = grant[1] ? req1_src   : req0_src;
                    hold_shamt_d = grant[1] ? req1_shamt : req0_shamt;
                    hold_dir_d   = grant[1] ? req1_dir   : req0_dir;
                    rsp_id_d     = grant[1];
                    last_d       = grant[1];
                    cnt_d        = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SH_LAT)) begin
                    rsp_data_d  = sh_out;
                    rsp_zr_d    = sh_zr;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= 1'b1;
            hold_src_q   <= '0;
            hold_shamt_q <= '0;
            hold_dir_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            hold_src_q   <= hold_src_d;
            hold_shamt_q <= hold_shamt_d;
            hold_dir_q   <= hold_dir_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zr_q     <= rsp_zr_d;
        end
    end

    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];
    assign sh_src     = hold_src_q;
    assign sh_shamt   = hold_shamt_q;
    assign sh_dir     = hold_dir_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_zr     = rsp_zr_q;
    assign busy       = (state_q == BUSY);

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter. It runs directed scenarios against a pipelined shifter stand-in and
// a transaction-level model of arbitration and timing that is compared on every cycle.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_src = '0, req1_src = '0;
    logic [3:0]   req0_shamt = '0, req1_shamt = '0;
    logic [1:0]   req0_dir = '0, req1_dir = '0;
    logic [W-1:0] sh_src;
    logic [3:0]   sh_shamt;
    logic [1:0]   sh_dir;
    logic [W-1:0] sh_out;
    logic         sh_zr;
    logic         rsp_valid, rsp_id, rsp_zr, busy;
    logic [W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    shift_arbiter #(.WIDTH(W), .SH_LAT(SH_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_src(req0_src), .req1_src(req1_src),
        .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
        .req0_dir(req0_dir), .req1_dir(req1_dir),
        .sh_src(sh_src), .sh_shamt(sh_shamt), .sh_dir(sh_dir),
        .sh_out(sh_out), .sh_zr(sh_zr),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zr(rsp_zr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] shiftRef(input logic [W-1:0] s, input logic [3:0] a,
                                              input logic [1:0] d);
        case (d)
            SH_SLL:  return s << a;
            SH_SRL:  return s >> a;
            SH_SRA:  return W'($signed(s) >>> a);
            default: return s;
        endcase
    endfunction

    function automatic int pickWinner(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Shifter stand-in: result appears 4 edges after the operands are sampled, zero flag one edge later.
    logic [W-1:0] pipe [4] = '{default: '0};
    logic         zr_q = 1'b0;
    always @(posedge clk) begin
        pipe[0] <= shiftRef(sh_src, sh_shamt, sh_dir);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
        zr_q    <= (pipe[3] == '0);
    end
    assign sh_out = pipe[3];
    assign sh_zr  = zr_q;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: m_left counts the cycles until the in-flight result is announced.
    int           m_left;
    logic         m_last, m_rsp_valid, m_rsp_id, m_rsp_zr;
    logic [W-1:0] m_sh_src, m_rsp_data;
    logic [3:0]   m_sh_shamt;
    logic [1:0]   m_sh_dir;

    always @(posedge clk) begin
        int w;
        logic [W-1:0] r;
        if (rst) begin
            m_left = 0; m_last = 1'b1; m_rsp_valid = 1'b0; m_rsp_id = 1'b0; m_rsp_zr = 1'b0;
            m_rsp_data = '0; m_sh_src = '0; m_sh_shamt = '0; m_sh_dir = '0;
        end else begin
            m_rsp_valid = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    r = shiftRef(m_sh_src, m_sh_shamt, m_sh_dir);
                    m_rsp_valid = 1'b1;
                    m_rsp_data  = r;
                    m_rsp_zr    = (r == '0);
                end
            end else begin
                w = pickWinner(req0_valid, req1_valid, m_last);
                if (w >= 0) begin
                    m_sh_src   = (w == 1) ? req1_src   : req0_src;
                    m_sh_shamt = (w == 1) ? req1_shamt : req0_shamt;
                    m_sh_dir   = (w == 1) ? req1_dir   : req0_dir;
                    m_rsp_id   = (w == 1);
                    m_last     = (w == 1);
                    m_left     = SH_LAT + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int w;
            w = pickWinner(req0_valid, req1_valid, m_last);
            checkOutput("req0_ready", req0_ready, (m_left == 0) && (w == 0));
            checkOutput("req1_ready", req1_ready, (m_left == 0) && (w == 1));
            checkOutput("busy", busy, m_left > 0);
            checkOutput("rsp_valid", rsp_valid, m_rsp_valid);
            checkOutput("rsp_id", rsp_id, m_rsp_id);
            checkOutput("rsp_data", rsp_data, m_rsp_data);
            checkOutput("rsp_zr", rsp_zr, m_rsp_zr);
            checkOutput("sh_src", sh_src, m_sh_src);
            checkOutput("sh_shamt", sh_shamt, m_sh_shamt);
            checkOutput("sh_dir", sh_dir, m_sh_dir);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic v, input logic [W-1:0] src,
                                 input logic [3:0] shamt, input logic [1:0] dir);
        if (port == 0) begin
            req0_valid = v; req0_src = src; req0_shamt = shamt; req0_dir = dir;
        end else begin
            req1_valid = v; req1_src = src; req1_shamt = shamt; req1_dir = dir;
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic waitRsp(input string name, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: rsp_valid actual=absent required=within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hs, at, seen, n0, n1, nr;
        int ids [6];
        int ats [6];

        resetDut();

        // Single request with the reset pointer.
        applyStimulus(0, 1'b1, 16'h0001, 4'd4, SH_SLL);
        hs = cyc;
        tick();
        applyStimulus(0, 1'b0, 16'h0001, 4'd4, SH_SLL);
        waitRsp("t1", 12, at);
        if (at >= 0) begin
            checkOutput("t1_latency", at - hs, 7);
            checkOutput("t1_data", rsp_data, 16'h0010);
            checkOutput("t1_zr", rsp_zr, 1'b0);
            checkOutput("t1_id", rsp_id, 1'b0);
        end

        // Simultaneous requests right after reset: req0 first, req1 accepted on the result cycle.
        resetDut();
        applyStimulus(0, 1'b1, 16'h8000, 4'd3, SH_SRA);
        applyStimulus(1, 1'b1, 16'h8000, 4'd15, SH_SRL);
        hs = cyc;
        tick();
        applyStimulus(0, 1'b0, 16'h8000, 4'd3, SH_SRA);
        waitRsp("t2a", 12, at);
        if (at >= 0) begin
            checkOutput("t2a_latency", at - hs, 7);
            checkOutput("t2a_data", rsp_data, 16'hF000);
            checkOutput("t2a_id", rsp_id, 1'b0);
            checkOutput("t2a_req1_ready", req1_ready, 1'b1);
        end
        tick();
        applyStimulus(1, 1'b0, 16'h8000, 4'd15, SH_SRL);
        waitRsp("t2b", 12, at);
        if (at >= 0) begin
            checkOutput("t2b_latency", at - hs, 14);
            checkOutput("t2b_data", rsp_data, 16'h0001);
            checkOutput("t2b_id", rsp_id, 1'b1);
        end

        // Zero result, then pass-through.
        tick();
        applyStimulus(1, 1'b1, 16'h00FF, 4'd8, SH_SRL);
        tick();
        applyStimulus(1, 1'b0, 16'h00FF, 4'd8, SH_SRL);
        waitRsp("t3a", 12, at);
        if (at >= 0) begin
            checkOutput("t3a_data", rsp_data, 16'h0000);
            checkOutput("t3a_zr", rsp_zr, 1'b1);
        end
        tick();
        applyStimulus(1, 1'b1, 16'h1234, 4'd5, SH_PASS);
        tick();
        applyStimulus(1, 1'b0, 16'h1234, 4'd5, SH_PASS);
        waitRsp("t3b", 12, at);
        if (at >= 0) begin
            checkOutput("t3b_data", rsp_data, 16'h1234);
            checkOutput("t3b_zr", rsp_zr, 1'b0);
        end

        // Operands change after acceptance; the shifter inputs must not.
        tick();
        applyStimulus(0, 1'b1, 16'h0003, 4'd1, SH_SLL);
        tick();
        applyStimulus(0, 1'b0, 16'hFFFF, 4'd15, SH_SLL);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t4_sh_src_c%0d", k), sh_src, 16'h0003);
            checkOutput($sformatf("t4_sh_shamt_c%0d", k), sh_shamt, 4'd1);
            checkOutput($sformatf("t4_sh_dir_c%0d", k), sh_dir, SH_SLL);
        end
        waitRsp("t4", 4, at);
        if (at >= 0) checkOutput("t4_data", rsp_data, 16'h0006);

        // Reset in cycle 3 of an operation discards it.
        tick();
        applyStimulus(0, 1'b1, 16'h0001, 4'd1, SH_SLL);
        tick();
        applyStimulus(0, 1'b0, 16'h0001, 4'd1, SH_SLL);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_rsp_valid", rsp_valid, 1'b0);
        checkOutput("t5_rsp_data", rsp_data, 16'h0000);
        checkOutput("t5_sh_src", sh_src, 16'h0000);
        checkOutput("t5_sh_shamt", sh_shamt, 4'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1;
        end
        checkOutput("t5_no_rsp", seen, 0);
        tick();
        applyStimulus(1, 1'b1, 16'hF000, 4'd4, SH_SRL);
        hs = cyc;
        tick();
        applyStimulus(1, 1'b0, 16'hF000, 4'd4, SH_SRL);
        waitRsp("t5c", 12, at);
        if (at >= 0) begin
            checkOutput("t5c_latency", at - hs, 7);
            checkOutput("t5c_data", rsp_data, 16'h0F00);
            checkOutput("t5c_id", rsp_id, 1'b1);
        end

        // Reset wins over a simultaneous handshake.
        tick();
        applyStimulus(0, 1'b1, 16'h5555, 4'd2, SH_SLL);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 1'b0, 16'h5555, 4'd2, SH_SLL);
        @(negedge clk);
        checkOutput("t5d_busy", busy, 1'b0);
        checkOutput("t5d_sh_src", sh_src, 16'h0000);

        // Both requesters continuously valid: strict alternation, one result every 7 cycles.
        resetDut();
        applyStimulus(0, 1'b1, 16'h0101, 4'd3, SH_SLL);
        applyStimulus(1, 1'b1, 16'h8421, 4'd2, SH_SRA);
        n0 = 0; n1 = 0; nr = 0;
        for (int i = 0; i < 60 && nr < 6; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) n0++;
            if (req1_valid && req1_ready) n1++;
            if (rsp_valid === 1'b1) begin
                ids[nr] = int'(rsp_id);
                ats[nr] = cyc;
                nr++;
            end
            tick();
            req0_valid = (n0 < 3);
            req1_valid = (n1 < 3);
        end
        checkOutput("t6_rsp_count", nr, 6);
        for (int k = 0; k < nr; k++) begin
            checkOutput($sformatf("t6_id_%0d", k), ids[k], k % 2);
            if (k > 0) checkOutput($sformatf("t6_gap_%0d", k), ats[k] - ats[k-1], 7);
        end

        tick();
        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
